dkongjr_obj_scan: RTL and testbench

DKONGJR_OBJ_SCAN -- requirements
Module: dkongjr_obj_scan

---
 rtl/dkongjr_obj_pkg.sv | 43 ++++
 rtl/dkongjr_obj_linelist.sv | 40 ++++
 rtl/dkongjr_obj_scan.sv | 201 ++++++++++++++++++++
 tb/tb_dkongjr_obj_scan.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dkongjr_obj_pkg.sv
// Shared constants, FSM encoding and list-entry layout for the sprite line scanner.
package dkongjr_obj_pkg;

  localparam int SPR_COUNT  = 96;
  localparam int MAX_HITS   = 16;
  localparam int SPR_H      = 16;
  localparam int LIST_DEPTH = 16;

  // Byte offsets inside one 4-byte sprite RAM entry
  localparam logic [1:0] BYTE_Y    = 2'd0;
  localparam logic [1:0] BYTE_CODE = 2'd1;
  localparam logic [1:0] BYTE_ATTR = 2'd2;
  localparam logic [1:0] BYTE_X    = 2'd3;

  // Bit positions of the fields inside one 32-bit line-list entry
  localparam int FLD_YOFF_LSB = 0;
  localparam int FLD_CODE_LSB = 8;
  localparam int FLD_ATTR_LSB = 16;
  localparam int FLD_X_LSB    = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RDY   = 3'd1,
    ST_CMP   = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

  // Build a list entry {X, attr, code, Y-offset}; the Y-offset byte is zero-extended.
  function automatic logic [31:0] pack_entry(input logic [7:0] x,
                                             input logic [7:0] attr,
                                             input logic [7:0] code,
                                             input logic [3:0] yoff);
    logic [31:0] e;
    e = '0;
    e[FLD_X_LSB    +: 8] = x;
    e[FLD_ATTR_LSB +: 8] = attr;
    e[FLD_CODE_LSB +: 8] = code;
    e[FLD_YOFF_LSB +: 4] = yoff;
    return e;
  endfunction

endpackage

// File: rtl/dkongjr_obj_linelist.sv
// Two-bank 16x32 line list: scans write the back bank while the renderer reads the display bank.
module dkongjr_obj_linelist
  import dkongjr_obj_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        swap,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [31:0] wd,
  input  logic [3:0]  ra,
  output logic [31:0] rd,
  output logic        bank_sel
);

  logic [31:0] list_mem [0:1][0:LIST_DEPTH-1];
  logic        bank_q;
  logic        bank_d;

  // Flip the display bank only when a completed scan hands its list over
  always_comb begin
    bank_d = bank_q;
    if (swap) bank_d = ~bank_q;
  end

  // Bank select register; the display bank starts as bank 0
  always_ff @(posedge clk) begin
    if (rst) bank_q <= 1'b0;
    else     bank_q <= bank_d;
  end

  // Writes always land in the bank the renderer is not looking at; contents are not reset
  always_ff @(posedge clk) begin
    if (we) list_mem[~bank_q][wa] <= wd;
  end

  assign rd       = list_mem[bank_q][ra];
  assign bank_sel = bank_q;

endmodule

// File: rtl/dkongjr_obj_scan.sv
// Per-line sprite scanner: walks sprite RAM during hblank and builds the next line's sprite list.
module dkongjr_obj_scan
  import dkongjr_obj_pkg::*;
#(
  parameter int SPR_COUNT = dkongjr_obj_pkg::SPR_COUNT,
  parameter int MAX_HITS  = dkongjr_obj_pkg::MAX_HITS,
  parameter int SPR_H     = dkongjr_obj_pkg::SPR_H
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        I_SCAN_GO,
  input  logic [7:0]  I_VPOS,
  input  logic        I_DMA_BUSY,
  output logic [9:0]  O_RAM_A,
  input  logic [7:0]  I_RAM_D,
  input  logic [3:0]  I_LIST_RA,
  output logic [31:0] O_LIST_RD,
  output logic [4:0]  O_HIT_CNT,
  output logic        O_OVERFLOW,
  output logic        O_DONE,
  output logic        O_BUSY
);

  scan_state_e state_q, state_d;

  logic [6:0]  idx_q, idx_d;
  logic [1:0]  fetch_q, fetch_d;
  logic [7:0]  vpos_q, vpos_d;
  logic [3:0]  yoff_q, yoff_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  attr_q, attr_d;
  logic [4:0]  back_cnt_q, back_cnt_d;
  logic        back_ovf_q, back_ovf_d;
  logic [4:0]  disp_cnt_q, disp_cnt_d;
  logic        disp_ovf_q, disp_ovf_d;

  logic [7:0]  y_diff;
  logic        is_hit;
  logic        last_entry;
  logic        list_full;
  logic        go_ok;

  logic        list_we;
  logic        list_swap;
  logic [31:0] list_wd;
  logic        bank_sel_unused;

  // Hit test uses the wrapping line distance so sprites straddling line 0 still match
  always_comb begin
    y_diff     = vpos_q - I_RAM_D;
    is_hit     = int'(y_diff) < SPR_H;
    last_entry = (idx_q == 7'(SPR_COUNT - 1));
    list_full  = (back_cnt_q == 5'(MAX_HITS));
    go_ok      = I_SCAN_GO && !I_DMA_BUSY;
  end

  // State register
  always_ff @(posedge I_CLK) begin
    if (I_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DMA activity beats every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go_ok) state_d = ST_RDY;
      ST_RDY:   state_d = ST_CMP;
      ST_CMP: begin
        if (is_hit) state_d = list_full ? ST_DONE : ST_FETCH;
        else        state_d = last_entry ? ST_DONE : ST_RDY;
      end
      ST_FETCH: if (fetch_q == 2'd2) state_d = last_entry ? ST_DONE : ST_RDY;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && I_DMA_BUSY) state_d = ST_IDLE;
  end

  // Outputs: RAM address is pipelined one byte ahead of the data being consumed
  always_comb begin
    O_RAM_A   = '0;
    O_DONE    = 1'b0;
    O_BUSY    = (state_q != ST_IDLE);
    list_we   = 1'b0;
    list_swap = 1'b0;
    case (state_q)
      ST_RDY: O_RAM_A = {1'b0, idx_q, BYTE_Y};
      ST_CMP: O_RAM_A = {1'b0, idx_q, BYTE_CODE};
      ST_FETCH: begin
        case (fetch_q)
          2'd0:    O_RAM_A = {1'b0, idx_q, BYTE_ATTR};
          2'd1:    O_RAM_A = {1'b0, idx_q, BYTE_X};
          default: O_RAM_A = {1'b0, idx_q, BYTE_Y};
        endcase
        list_we = (fetch_q == 2'd2) && !I_DMA_BUSY;
      end
      ST_DONE: begin
        O_DONE    = !I_DMA_BUSY;
        list_swap = !I_DMA_BUSY;
      end
      default: ;
    endcase
  end

  // Datapath: capture the line, sprite fields, back-bank tallies and the display copies
  always_comb begin
    idx_d      = idx_q;
    fetch_d    = fetch_q;
    vpos_d     = vpos_q;
    yoff_d     = yoff_q;
    code_d     = code_q;
    attr_d     = attr_q;
    back_cnt_d = back_cnt_q;
    back_ovf_d = back_ovf_q;
    disp_cnt_d = disp_cnt_q;
    disp_ovf_d = disp_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (go_ok) begin
          vpos_d     = I_VPOS;
          idx_d      = '0;
          back_cnt_d = '0;
          back_ovf_d = 1'b0;
        end
      end
      ST_CMP: begin
        yoff_d  = y_diff[3:0];
        fetch_d = '0;
        if (!is_hit && !last_entry) idx_d = idx_q + 7'd1;
        if (is_hit && list_full)    back_ovf_d = 1'b1;
      end
      ST_FETCH: begin
        fetch_d = fetch_q + 2'd1;
        case (fetch_q)
          2'd0: code_d = I_RAM_D;
          2'd1: attr_d = I_RAM_D;
          default: begin
            back_cnt_d = back_cnt_q + 5'd1;
            if (!last_entry) idx_d = idx_q + 7'd1;
          end
        endcase
      end
      ST_DONE: begin
        if (!I_DMA_BUSY) begin
          disp_cnt_d = back_cnt_q;
          disp_ovf_d = back_ovf_q;
        end
      end
      default: ;
    endcase
    if (state_q != ST_IDLE && I_DMA_BUSY) begin
      back_cnt_d = '0;
      back_ovf_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      idx_q      <= '0;
      fetch_q    <= '0;
      vpos_q     <= '0;
      yoff_q     <= '0;
      code_q     <= '0;
      attr_q     <= '0;
      back_cnt_q <= '0;
      back_ovf_q <= 1'b0;
      disp_cnt_q <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      fetch_q    <= fetch_d;
      vpos_q     <= vpos_d;
      yoff_q     <= yoff_d;
      code_q     <= code_d;
      attr_q     <= attr_d;
      back_cnt_q <= back_cnt_d;
      back_ovf_q <= back_ovf_d;
      disp_cnt_q <= disp_cnt_d;
      disp_ovf_q <= disp_ovf_d;
    end
  end

  assign list_wd    = pack_entry(I_RAM_D, attr_q, code_q, yoff_q);
  assign O_HIT_CNT  = disp_cnt_q;
  assign O_OVERFLOW = disp_ovf_q;

  dkongjr_obj_linelist u_linelist (
    .clk      (I_CLK),
    .rst      (I_RST),
    .swap     (list_swap),
    .we       (list_we),
    .wa       (back_cnt_q[3:0]),
    .wd       (list_wd),
    .ra       (I_LIST_RA),
    .rd       (O_LIST_RD),
    .bank_sel (bank_sel_unused)
  );

endmodule

// File: tb/tb_dkongjr_obj_scan.sv
// Directed bench for the sprite line scanner with a one-cycle-latency sprite RAM model.
module tb_dkongjr_obj_scan;

  logic        I_CLK = 1'b0;
  logic        I_RST = 1'b1;
  logic        I_SCAN_GO = 1'b0;
  logic [7:0]  I_VPOS = 8'h00;
  logic        I_DMA_BUSY = 1'b0;
  logic [9:0]  O_RAM_A;
  logic [7:0]  I_RAM_D = 8'h00;
  logic [3:0]  I_LIST_RA = 4'h0;
  logic [31:0] O_LIST_RD;
  logic [4:0]  O_HIT_CNT;
  logic        O_OVERFLOW;
  logic        O_DONE;
  logic        O_BUSY;

  int total = 0;
  int bad   = 0;
  int doneCycle;
  int doneCount;
  int stopCycle;

  logic [7:0] sprRam [0:1023];

  typedef enum int {PAT_ALL_OFF, PAT_ONE, PAT_WRAP, PAT_TWENTY} pat_e;

  typedef struct {
    pat_e        pat;
    logic [7:0]  vpos;
    int          expCycle;
    logic [4:0]  expCnt;
    logic        expOvf;
    logic [31:0] expEntry0;
  } vec_t;

  vec_t vecs [6];

  dkongjr_obj_scan dut (
    .I_CLK      (I_CLK),
    .I_RST      (I_RST),
    .I_SCAN_GO  (I_SCAN_GO),
    .I_VPOS     (I_VPOS),
    .I_DMA_BUSY (I_DMA_BUSY),
    .O_RAM_A    (O_RAM_A),
    .I_RAM_D    (I_RAM_D),
    .I_LIST_RA  (I_LIST_RA),
    .O_LIST_RD  (O_LIST_RD),
    .O_HIT_CNT  (O_HIT_CNT),
    .O_OVERFLOW (O_OVERFLOW),
    .O_DONE     (O_DONE),
    .O_BUSY     (O_BUSY)
  );

  always #5 I_CLK = ~I_CLK;

  // Synchronous sprite RAM: data follows the address by one clock
  always @(posedge I_CLK) I_RAM_D <= sprRam[O_RAM_A];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadPattern(input pat_e pat);
    for (int n = 0; n < 256; n++) begin
      sprRam[4*n]     = 8'hF0;
      sprRam[4*n + 1] = 8'h00;
      sprRam[4*n + 2] = 8'h00;
      sprRam[4*n + 3] = 8'h00;
    end
    case (pat)
      PAT_ONE: begin
        sprRam[20] = 8'h20; sprRam[21] = 8'h3A; sprRam[22] = 8'h81; sprRam[23] = 8'h55;
      end
      PAT_WRAP: begin
        sprRam[0] = 8'hFA; sprRam[1] = 8'h11; sprRam[2] = 8'h22; sprRam[3] = 8'h33;
      end
      PAT_TWENTY: begin
        for (int n = 0; n < 20; n++) begin
          sprRam[4*n]     = 8'h40;
          sprRam[4*n + 1] = 8'(n);
          sprRam[4*n + 2] = 8'(8'h80 | n);
          sprRam[4*n + 3] = 8'(8'h10 + n);
        end
      end
      default: ;
    endcase
  endtask

  // Pulse I_SCAN_GO and follow the scan; cycle 0 is the pulse cycle. Optional extra GO / DMA pulses.
  task automatic applyStimulus(input logic [7:0] vpos, input int midGo, input int dmaAt);
    int cyc;
    doneCycle = -1;
    doneCount = 0;
    stopCycle = -1;
    @(posedge I_CLK); #1;
    I_VPOS = vpos;
    I_SCAN_GO = 1'b1;
    @(posedge I_CLK); #1;
    I_SCAN_GO = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (O_DONE) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if (!O_BUSY) begin
        stopCycle = cyc;
        break;
      end
      I_SCAN_GO  = (cyc == midGo);
      I_VPOS     = (cyc == midGo) ? 8'hF5 : vpos;
      I_DMA_BUSY = (cyc == dmaAt);
      @(posedge I_CLK); #1;
      cyc++;
    end
    I_SCAN_GO  = 1'b0;
    I_DMA_BUSY = 1'b0;
    I_VPOS     = vpos;
    if (stopCycle < 0) checkOutput("scan_cycle_bound", 32'(cyc), 32'd0);
  endtask

  initial begin
    int idleDone;

    vecs[0] = '{PAT_ALL_OFF, 8'h10, 193, 5'd0,  1'b0, 32'h0};
    vecs[1] = '{PAT_ONE,     8'h2F, 196, 5'd1,  1'b0, 32'h55813A0F};
    vecs[2] = '{PAT_ONE,     8'h30, 193, 5'd0,  1'b0, 32'h0};
    vecs[3] = '{PAT_WRAP,    8'h03, 196, 5'd1,  1'b0, 32'h33221109};
    vecs[4] = '{PAT_TWENTY,  8'h45, 83,  5'd16, 1'b1, 32'h10800005};
    vecs[5] = '{PAT_ALL_OFF, 8'h10, 193, 5'd0,  1'b0, 32'h0};

    loadPattern(PAT_ALL_OFF);
    repeat (3) @(posedge I_CLK);
    #1;
    checkOutput("reset_busy",     32'(O_BUSY),     32'd0);
    checkOutput("reset_done",     32'(O_DONE),     32'd0);
    checkOutput("reset_ram_a",    32'(O_RAM_A),    32'd0);
    checkOutput("reset_hit_cnt",  32'(O_HIT_CNT),  32'd0);
    checkOutput("reset_overflow", 32'(O_OVERFLOW), 32'd0);
    I_RST = 1'b0;

    for (int v = 0; v < 6; v++) begin
      loadPattern(vecs[v].pat);
      applyStimulus(vecs[v].vpos, -1, -1);
      checkOutput($sformatf("v%0d_done_cycle", v), 32'(doneCycle), 32'(vecs[v].expCycle));
      checkOutput($sformatf("v%0d_done_count", v), 32'(doneCount), 32'd1);
      checkOutput($sformatf("v%0d_hit_cnt", v),    32'(O_HIT_CNT), 32'(vecs[v].expCnt));
      checkOutput($sformatf("v%0d_overflow", v),   32'(O_OVERFLOW), 32'(vecs[v].expOvf));
      if (vecs[v].expCnt != 0) begin
        I_LIST_RA = 4'd0; #1;
        checkOutput($sformatf("v%0d_entry0", v), O_LIST_RD, vecs[v].expEntry0);
      end
      if (vecs[v].expCnt == 5'd16) begin
        for (int k = 0; k < 16; k++) begin
          I_LIST_RA = 4'(k); #1;
          checkOutput($sformatf("v%0d_entry%0d", v, k), O_LIST_RD,
                      {8'(8'h10 + k), 8'(8'h80 | k), 8'(k), 8'h05});
        end
      end
    end

    // DMA abort mid-scan leaves the display bank alone
    loadPattern(PAT_ONE);
    applyStimulus(8'h2F, -1, -1);
    checkOutput("pre_abort_cnt", 32'(O_HIT_CNT), 32'd1);
    loadPattern(PAT_TWENTY);
    applyStimulus(8'h45, -1, 20);
    checkOutput("abort_done_count", 32'(doneCount), 32'd0);
    checkOutput("abort_stop_cycle", 32'(stopCycle), 32'd21);
    checkOutput("abort_hit_cnt",    32'(O_HIT_CNT), 32'd1);
    checkOutput("abort_overflow",   32'(O_OVERFLOW), 32'd0);
    I_LIST_RA = 4'd0; #1;
    checkOutput("abort_entry0", O_LIST_RD, 32'h55813A0F);

    // GO while DMA is active is ignored
    I_SCAN_GO = 1'b1; I_DMA_BUSY = 1'b1;
    @(posedge I_CLK); #1;
    I_SCAN_GO = 1'b0; I_DMA_BUSY = 1'b0;
    checkOutput("go_during_dma_busy", 32'(O_BUSY), 32'd0);

    // Second GO mid-scan must not restart or pick up the new line
    loadPattern(PAT_ALL_OFF);
    applyStimulus(8'h10, 50, -1);
    checkOutput("midgo_done_cycle", 32'(doneCycle), 32'd193);
    checkOutput("midgo_done_count", 32'(doneCount), 32'd1);
    checkOutput("midgo_hit_cnt",    32'(O_HIT_CNT), 32'd0);
    checkOutput("midgo_overflow",   32'(O_OVERFLOW), 32'd0);

    // Reset while fetching a hit
    loadPattern(PAT_ONE);
    applyStimulus(8'h2F, -1, -1);
    checkOutput("pre_reset_cnt", 32'(O_HIT_CNT), 32'd1);
    loadPattern(PAT_TWENTY);
    @(posedge I_CLK); #1;
    I_VPOS = 8'h45; I_SCAN_GO = 1'b1;
    @(posedge I_CLK); #1;
    I_SCAN_GO = 1'b0;
    repeat (2) @(posedge I_CLK);
    #1;
    checkOutput("fetch_busy", 32'(O_BUSY), 32'd1);
    I_RST = 1'b1;
    @(posedge I_CLK); #1;
    checkOutput("rst_fetch_busy",     32'(O_BUSY),     32'd0);
    checkOutput("rst_fetch_hit_cnt",  32'(O_HIT_CNT),  32'd0);
    checkOutput("rst_fetch_overflow", 32'(O_OVERFLOW), 32'd0);
    checkOutput("rst_fetch_ram_a",    32'(O_RAM_A),    32'd0);
    checkOutput("rst_fetch_done",     32'(O_DONE),     32'd0);
    I_RST = 1'b0;
    idleDone = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge I_CLK); #1;
      if (O_DONE || O_BUSY) idleDone++;
    end
    checkOutput("rst_stays_idle", 32'(idleDone), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
